pixel_stream_binarizer: RTL

Upstream stage of the bounding-box path. Accepts the raw RGB byte stream (one byte per `wr_en` cycle on `hex_value_index[31:24]`, R,G,B per pixel, raster order), assembles pixels, classifies each as foreground or background against a threshold, and emits one registered pixel record per pixel with its (x, y) coordinate and frame markers. The bounding-box stage consumes `pix_valid`/`pix_x`/`pix_y`/`pix_fg` directly.

---
 rtl/pixel_stream_binarizer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pixel_stream_binarizer.sv
// Byte-stream RGB pixel assembler and binarizer: emits one registered record per pixel with (x, y) and frame markers.
// Optional macro PIXEL_LUMA_EN switches classification from per-channel thresholds to a (R+2G+B)/4 luma metric.
module pixel_stream_binarizer #(
   parameter int          WIDTH     = 100,
   parameter int          HEIGHT    = 100,
   parameter logic [7:0]  THRESHOLD = 8'd128,
   parameter logic [23:0] RESET_CMD = 24'd99999,
   localparam int         XW        = $clog2(WIDTH),
   localparam int         YW        = $clog2(HEIGHT)
) (
   input  logic          CLOCK_50,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [31:0]   hex_value_index,
   output logic          pix_valid,
   output logic [XW-1:0] pix_x,
   output logic [YW-1:0] pix_y,
   output logic          pix_fg,
   output logic          frame_start,
   output logic          frame_done,
   output logic          busy
);

   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

   logic [1:0]    r_phase;
   logic [7:0]    r_r;
   logic [7:0]    r_g;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic          r_pix_valid;
   logic [XW-1:0] r_pix_x;
   logic [YW-1:0] r_pix_y;
   logic          r_pix_fg;
   logic          r_frame_start;
   logic          r_frame_done;
   logic          r_busy;

   logic [7:0]    w_byte;
   logic          w_soft;
   logic          w_x_last;
   logic          w_y_last;
   logic          w_fg;

   assign w_byte   = hex_value_index[31:24];
   // The command field only matters while the strobe is low; with wr_en high the word is pure data.
   assign w_soft   = !wr_en && (hex_value_index[23:0] == RESET_CMD);
   assign w_x_last = (r_x == X_LAST);
   assign w_y_last = (r_y == Y_LAST);

`ifdef PIXEL_LUMA_EN
   logic [9:0] w_sum;
   logic [9:0] w_metric;
   assign w_sum    = {2'b00, r_r} + {1'b0, r_g, 1'b0} + {2'b00, w_byte};
   assign w_metric = w_sum >> 2;
   assign w_fg     = (w_metric < {2'b00, THRESHOLD});
`else
   assign w_fg     = (r_r < THRESHOLD) && (r_g < THRESHOLD) && (w_byte < THRESHOLD);
`endif

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_phase       <= 2'd0;
         r_r           <= 8'd0;
         r_g           <= 8'd0;
         r_x           <= '0;
         r_y           <= '0;
         r_pix_valid   <= 1'b0;
         r_pix_x       <= '0;
         r_pix_y       <= '0;
         r_pix_fg      <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_done  <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_pix_valid   <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_done  <= 1'b0;
         if (wr_en) begin
            r_busy <= 1'b1;
            case (r_phase)
               2'd0: begin
                  r_r     <= w_byte;
                  r_phase <= 2'd1;
               end
               2'd1: begin
                  r_g     <= w_byte;
                  r_phase <= 2'd2;
               end
               2'd2: begin
                  r_phase       <= 2'd0;
                  r_pix_valid   <= 1'b1;
                  r_pix_x       <= r_x;
                  r_pix_y       <= r_y;
                  r_pix_fg      <= w_fg;
                  r_frame_start <= (r_x == '0) && (r_y == '0);
                  r_frame_done  <= w_x_last && w_y_last;
                  if (w_x_last) begin
                     r_x <= '0;
                     r_y <= w_y_last ? '0 : r_y + 1'b1;
                  end else begin
                     r_x <= r_x + 1'b1;
                  end
               end
               default: r_phase <= 2'd0;
            endcase
         end else if (w_soft) begin
            r_phase <= 2'd0;
            r_x     <= '0;
            r_y     <= '0;
            r_busy  <= 1'b0;
         end else if (r_frame_done) begin
            // Drop busy one cycle after the last pixel unless a new frame's first byte arrived.
            r_busy <= 1'b0;
         end
      end
   end

   assign pix_valid   = r_pix_valid;
   assign pix_x       = r_pix_x;
   assign pix_y       = r_pix_y;
   assign pix_fg      = r_pix_fg;
   assign frame_start = r_frame_start;
   assign frame_done  = r_frame_done;
   assign busy        = r_busy;

endmodule
